// File: rtl/branch_pred_unit_if.sv
// Fetch/execute-side bus of the branch prediction unit: lookup, training, flush and init status.
interface branch_pred_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                flush;
  logic                predValid;
  logic [PC_WIDTH-1:0] predPC;
  logic                predOutValid;
  logic                predHit;
  logic                predTaken;
  logic [PC_WIDTH-1:0] predTarget;
  logic                updValid;
  logic [PC_WIDTH-1:0] updPC;
  logic                updTaken;
  logic [PC_WIDTH-1:0] updTarget;
  logic                busy;

  modport master (
    output flush, predValid, predPC, updValid, updPC, updTaken, updTarget,
    input  predOutValid, predHit, predTaken, predTarget, busy
  );

  modport slave (
    input  flush, predValid, predPC, updValid, updPC, updTaken, updTarget,
    output predOutValid, predHit, predTaken, predTarget, busy
  );
endinterface

// File: rtl/branch_pred_unit.sv
// Direct-mapped BTB with per-entry direction counters and a hardware init walk.
// BRANCH_PRED_TWO_BIT_EN selects 2-bit saturating counters; default is a 1-bit last-outcome bit.
module branch_pred_unit #(
  parameter  int ENTRY_NUM   = 64,
  parameter  int PC_WIDTH    = 32,
  parameter  int TAG_WIDTH   = 10,
  localparam int INDEX_WIDTH = $clog2(ENTRY_NUM)
) (
  input logic               clk,
  input logic               rst,
  branch_pred_unit_if.slave bp
);
`ifdef BRANCH_PRED_TWO_BIT_EN
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_ALLOC = 2'b10;
`else
  localparam int CNT_W = 1;
  localparam logic [CNT_W-1:0] CNT_ALLOC = 1'b1;
`endif

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(ENTRY_NUM - 1);

  // table storage; valid bits are cleared by the init walk, not by reset
  logic                 valid_mem [ENTRY_NUM];
  logic [TAG_WIDTH-1:0] tag_mem   [ENTRY_NUM];
  logic [PC_WIDTH-1:0]  tgt_mem   [ENTRY_NUM];
  logic [CNT_W-1:0]     cnt_mem   [ENTRY_NUM];

  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   ov_q, ov_d;
  logic                   hit_q, hit_d;
  logic                   taken_q, taken_d;
  logic [PC_WIDTH-1:0]    tgt_q, tgt_d;

  logic [INDEX_WIDTH-1:0] p_idx, u_idx;
  logic [TAG_WIDTH-1:0]   p_tag, u_tag;
  logic                   p_hit, p_taken, u_hit, upd_en;
  logic [PC_WIDTH-1:0]    p_tgt;

  logic                   ent_we, ent_valid;
  logic [INDEX_WIDTH-1:0] ent_idx;
  logic [PC_WIDTH-1:0]    ent_tgt;
  logic [CNT_W-1:0]       ent_cnt, u_cnt;
  logic                   unused_pc;

  assign p_idx = bp.predPC[INDEX_WIDTH+1:2];
  assign p_tag = bp.predPC[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
  assign u_idx = bp.updPC[INDEX_WIDTH+1:2];
  assign u_tag = bp.updPC[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
  assign unused_pc = ^{bp.predPC[1:0], bp.predPC[PC_WIDTH-1:INDEX_WIDTH+TAG_WIDTH+2],
                       bp.updPC[1:0],  bp.updPC[PC_WIDTH-1:INDEX_WIDTH+TAG_WIDTH+2]};

  assign p_hit   = valid_mem[p_idx] && (tag_mem[p_idx] == p_tag);
  assign p_taken = p_hit && cnt_mem[p_idx][CNT_W-1];
  assign p_tgt   = p_taken ? tgt_mem[p_idx] : bp.predPC + PC_WIDTH'(4);

  assign u_hit  = valid_mem[u_idx] && (tag_mem[u_idx] == u_tag);
  assign u_cnt  = cnt_mem[u_idx];
  // flush beats a same-cycle update; updates during init are dropped
  assign upd_en = bp.updValid && (state_q == ST_READY) && !bp.flush;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (bp.flush) begin
      state_d = ST_INIT;
      idx_d   = '0;
    end else if (state_q == ST_INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) state_d = ST_READY;
    end
  end

  always_comb begin
    ent_we    = 1'b0;
    ent_idx   = u_idx;
    ent_valid = 1'b1;
    ent_tgt   = bp.updTarget;
    ent_cnt   = CNT_ALLOC;
    if (state_q == ST_INIT) begin
      ent_we    = 1'b1;
      ent_idx   = idx_q;
      ent_valid = 1'b0;
    end else if (upd_en && u_hit) begin
      ent_we  = 1'b1;
      ent_tgt = bp.updTaken ? bp.updTarget : tgt_mem[u_idx];
`ifdef BRANCH_PRED_TWO_BIT_EN
      if (bp.updTaken) ent_cnt = (u_cnt == 2'b11) ? u_cnt : u_cnt + 2'b01;
      else             ent_cnt = (u_cnt == 2'b00) ? u_cnt : u_cnt - 2'b01;
`else
      ent_cnt = bp.updTaken;
`endif
    end else if (upd_en && bp.updTaken) begin
      ent_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ent_we) begin
      valid_mem[ent_idx] <= ent_valid;
      tag_mem[ent_idx]   <= u_tag;
      tgt_mem[ent_idx]   <= ent_tgt;
      cnt_mem[ent_idx]   <= ent_cnt;
    end
  end

  // prediction registers hold their last value while no lookup is accepted
  always_comb begin
    ov_d    = bp.predValid && (state_q == ST_READY);
    hit_d   = hit_q;
    taken_d = taken_q;
    tgt_d   = tgt_q;
    if (ov_d) begin
      hit_d   = p_hit;
      taken_d = p_taken;
      tgt_d   = p_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      ov_q    <= 1'b0;
      hit_q   <= 1'b0;
      taken_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ov_q    <= ov_d;
      hit_q   <= hit_d;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
    end
  end

  assign bp.predOutValid = ov_q;
  assign bp.predHit      = hit_q;
  assign bp.predTaken    = taken_q;
  assign bp.predTarget   = tgt_q;
  assign bp.busy         = (state_q == ST_INIT);
endmodule
